// File: rtl/eth_rx_cmd_ctrl.sv
// Receive-side command controller: parses 8-byte command frames from the UDP
// payload stream and turns them into start/stop requests, counting bad frames.
module eth_rx_cmd_ctrl #(
    parameter logic [7:0]  SYNC0     = 8'h55,
    parameter logic [7:0]  SYNC1     = 8'hA5,
    parameter logic [7:0]  CMD_START = 8'h01,
    parameter logic [7:0]  CMD_STOP  = 8'h02,
    parameter logic [31:0] MAX_NUM   = 32'h00FF_FFFF
) (
    input  logic        clk125M,
    input  logic        reset,
    input  logic        rx_data_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_pkt_done,
    input  logic        send_idle,
    output logic        restart_req,
    output logic [31:0] total_data_num,
    output logic        stop_req,
    output logic        start_pending,
    output logic [7:0]  cmd_err_cnt,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        CMD  = 3'd2,
        NUM  = 3'd3,
        CHK  = 3'd4,
        TAIL = 3'd5,
        DROP = 3'd6
    } state_t;

    state_t      state, byte_state, next_state;
    logic [7:0]  cmd_reg, xor_acc;
    logic [31:0] num_reg;
    logic [1:0]  byte_cnt;
    logic        byte_err, done_err, exec_start, exec_stop, num_ok;

    // Handshake: restart_req is high in any cycle where start_pending and
    // send_idle are both high; the send controller takes it on the next edge,
    // and start_pending drops on that same edge, so each request fires once.
    assign restart_req = start_pending && send_idle;
    assign num_ok      = (num_reg != 32'd0) && (num_reg <= MAX_NUM);
    assign state_dbg   = state;

    always_ff @(posedge clk125M or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // The byte is applied first; end-of-packet then acts on the resulting state.
    always_comb begin
        byte_state = state;
        byte_err   = 1'b0;
        if (rx_data_valid) begin
            case (state)
                IDLE: begin
                    byte_state = (rx_data == SYNC0) ? SYNC : DROP;
                    byte_err   = (rx_data != SYNC0);
                end
                SYNC: begin
                    byte_state = (rx_data == SYNC1) ? CMD : DROP;
                    byte_err   = (rx_data != SYNC1);
                end
                CMD:  byte_state = NUM;
                NUM:  byte_state = (byte_cnt == 2'd3) ? CHK : NUM;
                CHK: begin
                    byte_state = (rx_data == xor_acc) ? TAIL : DROP;
                    byte_err   = (rx_data != xor_acc);
                end
                TAIL: begin
                    byte_state = DROP;
                    byte_err   = 1'b1;
                end
                DROP:    byte_state = DROP;
                default: byte_state = IDLE;
            endcase
        end

        next_state = byte_state;
        done_err   = 1'b0;
        exec_start = 1'b0;
        exec_stop  = 1'b0;
        if (rx_pkt_done) begin
            next_state = IDLE;
            case (byte_state)
                SYNC, CMD, NUM, CHK: done_err = 1'b1;
                TAIL: begin
                    if (cmd_reg == CMD_START && num_ok) exec_start = 1'b1;
                    else if (cmd_reg == CMD_STOP)       exec_stop  = 1'b1;
                    else                                done_err   = 1'b1;
                end
                default: done_err = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk125M or posedge reset) begin
        if (reset) begin
            cmd_reg  <= 8'd0;
            xor_acc  <= 8'd0;
            num_reg  <= 32'd0;
            byte_cnt <= 2'd0;
        end else if (rx_data_valid) begin
            case (state)
                CMD: begin
                    cmd_reg  <= rx_data;
                    xor_acc  <= rx_data;
                    byte_cnt <= 2'd0;
                end
                NUM: begin
                    num_reg  <= {num_reg[23:0], rx_data};
                    xor_acc  <= xor_acc ^ rx_data;
                    byte_cnt <= byte_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk125M or posedge reset) begin
        if (reset) begin
            total_data_num <= 32'd0;
            start_pending  <= 1'b0;
            stop_req       <= 1'b0;
            cmd_err_cnt    <= 8'd0;
        end else begin
            stop_req <= exec_stop;
            if (exec_start) begin
                total_data_num <= num_reg;
                start_pending  <= 1'b1;
            end else if (exec_stop || restart_req) begin
                start_pending  <= 1'b0;
            end
            if ((byte_err || done_err) && cmd_err_cnt != 8'hFF)
                cmd_err_cnt <= cmd_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_eth_rx_cmd_ctrl.sv
// Bench for eth_rx_cmd_ctrl: packet-level reference model checked every cycle,
// a table of frame vectors, hand-written corner sequences and random traffic.
module tb_eth_rx_cmd_ctrl;

    localparam logic [7:0]  SYNC0     = 8'h55;
    localparam logic [7:0]  SYNC1     = 8'hA5;
    localparam logic [7:0]  CMD_START = 8'h01;
    localparam logic [7:0]  CMD_STOP  = 8'h02;
    localparam logic [31:0] MAX_NUM   = 32'h00FF_FFFF;

    // ---------------- clock / reset / DUT ----------------
    logic        clk125M = 1'b0;
    logic        reset = 1'b1;
    logic        rx_data_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_pkt_done = 1'b0;
    logic        send_idle = 1'b0;
    logic        restart_req, stop_req, start_pending;
    logic [31:0] total_data_num;
    logic [7:0]  cmd_err_cnt;
    logic [2:0]  state_dbg;

    always #4 clk125M = ~clk125M;

    eth_rx_cmd_ctrl dut (
        .clk125M        (clk125M),
        .reset          (reset),
        .rx_data_valid  (rx_data_valid),
        .rx_data        (rx_data),
        .rx_pkt_done    (rx_pkt_done),
        .send_idle      (send_idle),
        .restart_req    (restart_req),
        .total_data_num (total_data_num),
        .stop_req       (stop_req),
        .start_pending  (start_pending),
        .cmd_err_cnt    (cmd_err_cnt),
        .state_dbg      (state_dbg)
    );

    // ---------------- reference model / scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    bit          m_pending;
    logic [31:0] m_total;
    bit          m_stop;
    int          m_err;
    logic [7:0]  pkt_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] exp_q[$];
    int          restart_seen = 0;
    int          stop_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pending = 1'b0;
        m_total   = 32'd0;
        m_stop    = 1'b0;
        m_err     = 0;
        pkt_q.delete();
        exp_q.delete();
    endfunction

    function automatic void model_err();
        if (m_err < 255) m_err++;
    endfunction

    // Judge a whole packet by the frame rules; applied at the end-of-packet edge.
    function automatic void eval_packet();
        int          n;
        bit          bad;
        logic [7:0]  x;
        logic [31:0] num;
        n   = pkt_q.size();
        bad = 1'b0;
        if (n == 0) return;
        if (pkt_q[0] != SYNC0)                 bad = 1'b1;
        else if (n >= 2 && pkt_q[1] != SYNC1)  bad = 1'b1;
        else if (n < 8)                        bad = 1'b1;
        else begin
            x = pkt_q[2] ^ pkt_q[3] ^ pkt_q[4] ^ pkt_q[5] ^ pkt_q[6];
            if (x != pkt_q[7]) bad = 1'b1;
            else if (n > 8)    bad = 1'b1;
        end
        if (bad) begin
            model_err();
            return;
        end
        num = {pkt_q[3], pkt_q[4], pkt_q[5], pkt_q[6]};
        if (pkt_q[2] == CMD_START && num >= 32'd1 && num <= MAX_NUM) begin
            m_pending = 1'b1;
            m_total   = num;
        end else if (pkt_q[2] == CMD_STOP) begin
            m_pending = 1'b0;
            m_stop    = 1'b1;
        end else begin
            model_err();
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input bit v, input logic [7:0] d, input bit done, input bit idle);
        bit exp_restart;
        @(posedge clk125M); #1;
        rx_data_valid = v;
        rx_data       = d;
        rx_pkt_done   = done;
        send_idle     = idle;
        @(negedge clk125M);
        exp_restart = m_pending && idle;
        check("restart_req", 32'(restart_req), 32'(exp_restart));
        check("start_pending", 32'(start_pending), 32'(m_pending));
        check("stop_req", 32'(stop_req), 32'(m_stop));
        check("total_data_num", total_data_num, m_total);
        if (pkt_q.size() == 0) check("cmd_err_cnt", 32'(cmd_err_cnt), 32'(m_err));
        if (exp_restart) exp_q.push_back(m_total);
        if (restart_req) begin
            restart_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_restart: got restart_req=1 expected 0 at %0t", $time);
            end else begin
                check("restart_total", total_data_num, exp_q.pop_front());
            end
        end
        if (stop_req) stop_seen++;
        if (exp_restart) m_pending = 1'b0;
        m_stop = 1'b0;
        if (v) pkt_q.push_back(d);
        if (done) begin
            eval_packet();
            pkt_q.delete();
        end
    endtask

    function automatic bit idle_val(input int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return (mode == 1);
    endfunction

    task automatic idle(input int n, input int mode);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, idle_val(mode));
    endtask

    task automatic send_tx(input bit done_last, input int mode);
        int n;
        n = tx_q.size();
        for (int i = 0; i < n; i++)
            step(1'b1, tx_q[i], done_last && (i == n - 1), idle_val(mode));
        if (!done_last || n == 0) step(1'b0, 8'd0, 1'b1, idle_val(mode));
    endtask

    task automatic do_reset();
        @(posedge clk125M); #1;
        reset         = 1'b1;
        rx_data_valid = 1'b0;
        rx_pkt_done   = 1'b0;
        @(negedge clk125M);
        model_reset();
        check("rst_restart_req", 32'(restart_req), 32'd0);
        check("rst_total", total_data_num, 32'd0);
        check("rst_stop_req", 32'(stop_req), 32'd0);
        check("rst_pending", 32'(start_pending), 32'd0);
        check("rst_err_cnt", 32'(cmd_err_cnt), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk125M); #1;
        reset = 1'b0;
    endtask

    function automatic logic [63:0] frame64(input logic [7:0] cmd, input logic [31:0] num);
        logic [7:0] chk;
        chk = cmd ^ num[31:24] ^ num[23:16] ^ num[15:8] ^ num[7:0];
        return {SYNC0, SYNC1, cmd, num, chk};
    endfunction

    task automatic load_frame(input logic [7:0] cmd, input logic [31:0] num);
        logic [63:0] f;
        f = frame64(cmd, num);
        tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back(f[63 - 8*i -: 8]);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [79:0] bytes;
        int          len;
        bit          done_last;
        int          exp_restarts;
        int          exp_stops;
        int          exp_err_inc;
        logic [31:0] exp_total;
    } vec_t;

    function automatic vec_t mk(input logic [79:0] b, input int len, input bit dl,
                                input int r, input int s, input int e, input logic [31:0] t);
        vec_t v;
        v.bytes = b; v.len = len; v.done_last = dl;
        v.exp_restarts = r; v.exp_stops = s; v.exp_err_inc = e; v.exp_total = t;
        return v;
    endfunction

    vec_t        vt[15];
    int          r0, s0, err_base;
    logic [63:0] f0;

    initial begin
        f0     = frame64(CMD_START, 32'h0000_2E00);
        vt[0]  = mk({f0, 16'h0}, 8, 1'b0, 1, 0, 0, 32'd11776);
        vt[1]  = mk({f0 ^ 64'h1, 16'h0}, 8, 1'b0, 0, 0, 1, 32'd11776);
        vt[2]  = mk({f0, 8'hAA, 8'h00}, 9, 1'b0, 0, 0, 1, 32'd11776);
        vt[3]  = mk({f0, 16'h0}, 5, 1'b0, 0, 0, 1, 32'd11776);
        vt[4]  = mk({frame64(CMD_START, 32'h0000_0100), 16'h0}, 8, 1'b1, 1, 0, 0, 32'd256);
        vt[5]  = mk({frame64(CMD_START, 32'h0), 16'h0}, 8, 1'b0, 0, 0, 1, 32'd256);
        vt[6]  = mk({frame64(CMD_START, 32'h0100_0000), 16'h0}, 8, 1'b0, 0, 0, 1, 32'd256);
        vt[7]  = mk({frame64(CMD_STOP, 32'h1234_5678), 16'h0}, 8, 1'b0, 0, 1, 0, 32'd256);
        vt[8]  = mk({frame64(8'h07, 32'h10), 16'h0}, 8, 1'b0, 0, 0, 1, 32'd256);
        vt[9]  = mk({f0 ^ {8'hFF, 56'h0}, 16'h0}, 8, 1'b0, 0, 0, 1, 32'd256);
        vt[10] = mk({f0 ^ {8'h00, 8'h01, 48'h0}, 16'h0}, 8, 1'b1, 0, 0, 1, 32'd256);
        vt[11] = mk({frame64(CMD_START, MAX_NUM), 16'h0}, 8, 1'b1, 1, 0, 0, 32'h00FF_FFFF);
        vt[12] = mk({SYNC0, 72'h0}, 1, 1'b1, 0, 0, 1, 32'h00FF_FFFF);
        vt[13] = mk(80'h0, 0, 1'b0, 0, 0, 0, 32'h00FF_FFFF);
        vt[14] = mk({frame64(CMD_STOP, 32'h0), 16'h0}, 8, 1'b1, 0, 1, 0, 32'h00FF_FFFF);

        model_reset();
        do_reset();
        idle(2, 1);

        err_base = 0;
        for (int i = 0; i < 15; i++) begin
            r0 = restart_seen;
            s0 = stop_seen;
            tx_q.delete();
            for (int k = 0; k < vt[i].len; k++) tx_q.push_back(vt[i].bytes[79 - 8*k -: 8]);
            send_tx(vt[i].done_last, 1);
            idle(4, 1);
            err_base += vt[i].exp_err_inc;
            check($sformatf("vec%0d_restarts", i), 32'(restart_seen - r0), 32'(vt[i].exp_restarts));
            check($sformatf("vec%0d_stops", i), 32'(stop_seen - s0), 32'(vt[i].exp_stops));
            check($sformatf("vec%0d_err_cnt", i), 32'(cmd_err_cnt), 32'(err_base));
            check($sformatf("vec%0d_total", i), total_data_num, vt[i].exp_total);
        end

        // Start held off by send_idle, overwritten by a second start.
        r0 = restart_seen;
        load_frame(CMD_START, 32'h0000_2E00);
        send_tx(1'b0, 0);
        idle(50, 0);
        check("A_pending_hold", 32'(start_pending), 32'd1);
        check("A_no_restart_yet", 32'(restart_seen - r0), 32'd0);
        load_frame(CMD_START, 32'h0000_0100);
        send_tx(1'b0, 0);
        idle(3, 0);
        check("A_total_overwritten", total_data_num, 32'd256);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check("A_pulse", 32'(restart_req), 32'd1);
        check("A_pulse_total", total_data_num, 32'd256);
        idle(5, 1);
        check("A_one_pulse", 32'(restart_seen - r0), 32'd1);

        // Stop cancels a pending start.
        r0 = restart_seen;
        s0 = stop_seen;
        load_frame(CMD_START, 32'h0000_0500);
        send_tx(1'b1, 0);
        load_frame(CMD_STOP, 32'h0);
        send_tx(1'b0, 0);
        idle(3, 0);
        check("B_stop_pulse", 32'(stop_seen - s0), 32'd1);
        check("B_pending_cleared", 32'(start_pending), 32'd0);
        idle(10, 1);
        check("B_no_restart", 32'(restart_seen - r0), 32'd0);

        // Reset in the middle of a frame with a start pending.
        load_frame(CMD_START, 32'h0000_0700);
        send_tx(1'b0, 0);
        load_frame(CMD_START, 32'h0000_2E00);
        for (int i = 0; i < 5; i++) step(1'b1, tx_q[i], 1'b0, 1'b0);
        do_reset();
        r0 = restart_seen;
        for (int i = 5; i < 8; i++) step(1'b1, tx_q[i], 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b1, 1'b1);
        idle(4, 1);
        check("C_no_restart", 32'(restart_seen - r0), 32'd0);
        check("C_err_cnt", 32'(cmd_err_cnt), 32'd1);

        // Random traffic against the model.
        for (int p = 0; p < 300; p++) begin
            int          kind;
            logic [31:0] num;
            int          sel;
            kind = $urandom_range(0, 5);
            sel  = $urandom_range(0, 5);
            case (sel)
                0:       num = 32'd0;
                1:       num = MAX_NUM;
                2:       num = MAX_NUM + 32'd1;
                3:       num = $urandom;
                default: num = 32'($urandom_range(1, 16'hFFFF));
            endcase
            load_frame((kind == 2) ? CMD_STOP : CMD_START, num);
            if (kind == 3) begin
                int idx;
                idx = $urandom_range(0, 7);
                tx_q[idx] = tx_q[idx] ^ 8'($urandom_range(1, 255));
            end else if (kind == 4) begin
                int keep;
                keep = $urandom_range(0, 7);
                while (tx_q.size() > keep) void'(tx_q.pop_back());
            end else if (kind == 5) begin
                int extra;
                extra = $urandom_range(1, 2);
                for (int k = 0; k < extra; k++) tx_q.push_back(8'($urandom_range(0, 255)));
            end
            send_tx(1'($urandom_range(0, 1)), 2);
            idle($urandom_range(0, 3), 2);
        end
        idle(10, 1);
        check("rand_queue_drained", 32'(exp_q.size()), 32'd0);

        // Error counter saturation.
        do_reset();
        for (int p = 0; p < 300; p++) begin
            tx_q.delete();
            tx_q.push_back(8'h00);
            send_tx(1'b1, 1);
        end
        idle(3, 1);
        check("D_err_saturated", 32'(cmd_err_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
